// File: rtl/step_clk_ctrl.sv
// Execution-clock controller: programmable divider, gated one-cycle tick enable,
// and synchronised/debounced step and resume buttons. Everything runs on the board clock.
module step_clk_ctrl #(
    parameter int CNT_W       = 27,
    parameter int DIV_DEFAULT = 20000,
    parameter int NUM_BTN     = 2,
    parameter int DEB_CYC     = 1000000,
    parameter int DEB_W       = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   div_val,
    input  logic [1:0]         mode,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               halt_in,
    output logic               slow_clk,
    output logic               tick_en,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               running,
    output logic [15:0]        tick_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND,
        ST_BRK
    } state_t;

    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BREAK = 2'b11;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_DEFAULT);

    logic [NUM_BTN-1:0]            sync1_q;
    logic [NUM_BTN-1:0]            sync2_q;
    logic [NUM_BTN-1:0]            level_q;
    logic [NUM_BTN-1:0]            level_d;
    logic [NUM_BTN-1:0]            level_dly_q;
    logic [NUM_BTN-1:0]            pulse_q;
    logic [NUM_BTN-1:0]            pulse_d;
    logic [NUM_BTN-1:0][DEB_W-1:0] deb_cnt_q;
    logic [NUM_BTN-1:0][DEB_W-1:0] deb_cnt_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_act_q;
    logic [CNT_W-1:0] div_act_d;
    logic             slow_q;
    logic             slow_d;
    logic             wrap;
    logic             rise;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  mode_q;
    logic        mode_chg;
    logic        tick_q;
    logic        tick_d;
    logic [15:0] tick_count_q;
    logic [15:0] tick_count_d;

    // A level change is accepted only after the synced input disagrees for DEB_CYC cycles.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                level_d[i]   = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
        pulse_d = level_q & ~level_dly_q;
    end

    // The new divisor is only picked up at wrap, so a phase is never cut short.
    always_comb begin
        wrap      = (cnt_q == div_act_q);
        rise      = wrap & ~slow_q;
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        div_act_d = wrap ? div_val : div_act_q;
        slow_d    = wrap ? ~slow_q : slow_q;
    end

    always_comb begin
        mode_chg = (mode != mode_q);
        state_d  = state_q;
        tick_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_RUN || mode == MODE_BREAK) begin
                    state_d = ST_RUN;
                end else if (mode == MODE_STEP && pulse_q[0]) begin
                    state_d = ST_PEND;
                end
            end
            ST_RUN: begin
                tick_d = rise;
                if (rise && halt_in && mode == MODE_BREAK) begin
                    state_d = ST_BRK;
                end
            end
            ST_PEND: begin
                tick_d = rise;
                if (rise) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BRK: begin
                if (pulse_q[1]) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Tick above is still decided by the old state; only the next state is overridden.
        if (mode_chg) begin
            state_d = (mode == MODE_RUN) ? ST_RUN : ST_IDLE;
        end
        tick_count_d = tick_count_q + 16'(tick_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_dly_q  <= '0;
            pulse_q      <= '0;
            deb_cnt_q    <= '0;
            cnt_q        <= '0;
            div_act_q    <= DIV_RESET;
            slow_q       <= 1'b0;
            state_q      <= ST_IDLE;
            mode_q       <= 2'b00;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_dly_q  <= level_q;
            pulse_q      <= pulse_d;
            deb_cnt_q    <= deb_cnt_d;
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            slow_q       <= slow_d;
            state_q      <= state_d;
            mode_q       <= mode;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign slow_clk   = slow_q;
    assign tick_en    = tick_q;
    assign btn_pulse  = pulse_q;
    assign btn_level  = level_q;
    assign running    = (state_q == ST_RUN);
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed bench for step_clk_ctrl with small divider/debounce parameters.
// Expected waveforms are written as strings: character i is the value after the i-th clock edge.
module tb_step_clk_ctrl;

    logic        clk;
    logic        rst;
    logic [26:0] div_val;
    logic [1:0]  mode;
    logic [1:0]  btn_raw;
    logic        halt_in;
    logic        slow_clk;
    logic        tick_en;
    logic [1:0]  btn_pulse;
    logic [1:0]  btn_level;
    logic        running;
    logic [15:0] tick_count;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    step_clk_ctrl #(
        .CNT_W      (27),
        .DIV_DEFAULT(3),
        .NUM_BTN    (2),
        .DEB_CYC    (4),
        .DEB_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div_val   (div_val),
        .mode      (mode),
        .btn_raw   (btn_raw),
        .halt_in   (halt_in),
        .slow_clk  (slow_clk),
        .tick_en   (tick_en),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .running   (running),
        .tick_count(tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Let n clock edges pass; control returns on the following falling edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] charBit(input string s, input int i);
        return (s[i] == "1") ? 32'd1 : 32'd0;
    endfunction

    function automatic string rep(input string s, input int n);
        string r;
        r = "";
        for (int k = 0; k < n; k++) r = {r, s};
        return r;
    endfunction

    task automatic runWindow(input string tag, input string expTick, input string expSlow,
                             input string expRun, input string expP0, input string expP1);
        for (int i = 0; i < expTick.len(); i++) begin
            applyStimulus(1);
            checkOutput($sformatf("%s.tick[%0d]", tag, i), 32'(tick_en), charBit(expTick, i));
            if (i < expSlow.len())
                checkOutput($sformatf("%s.slow[%0d]", tag, i), 32'(slow_clk), charBit(expSlow, i));
            if (i < expRun.len())
                checkOutput($sformatf("%s.run[%0d]", tag, i), 32'(running), charBit(expRun, i));
            if (i < expP0.len())
                checkOutput($sformatf("%s.p0[%0d]", tag, i), 32'(btn_pulse[0]), charBit(expP0, i));
            if (i < expP1.len())
                checkOutput($sformatf("%s.p1[%0d]", tag, i), 32'(btn_pulse[1]), charBit(expP1, i));
        end
    endtask

    task automatic waitTick(input string tag, input int maxCyc);
        int k;
        k = 0;
        do begin
            applyStimulus(1);
            k++;
        end while (tick_en !== 1'b1 && k < maxCyc);
        checkOutput({tag, ".seen"}, 32'(tick_en), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".slow"},   32'(slow_clk),   32'd0);
        checkOutput({tag, ".tick"},   32'(tick_en),    32'd0);
        checkOutput({tag, ".count"},  32'(tick_count), 32'd0);
        checkOutput({tag, ".level"},  32'(btn_level),  32'd0);
        checkOutput({tag, ".pulse"},  32'(btn_pulse),  32'd0);
        checkOutput({tag, ".run"},    32'(running),    32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        mode    = 2'b01;
        div_val = 27'd3;
        btn_raw = 2'b00;
        halt_in = 1'b0;
        applyStimulus(2);
        checkAllZero("reset");

        // Run at the default divisor: 8-cycle period, tick with each rising slow_clk.
        $display("[TB] run mode, default divider");
        rst = 1'b1;
        runWindow("run", rep("00010000", 5), rep("00011110", 5), rep("1", 40), rep("0", 40), rep("0", 40));
        checkOutput("run.count", 32'(tick_count), 32'd5);

        // Shorter divisor requested mid-phase takes effect only after the current half-period.
        $display("[TB] divider changes");
        runWindow("div3", "0", "0", "1", "", "");
        div_val = 27'd1;
        runWindow("div1", rep("0010", 3), rep("0011", 3), rep("1", 12), "", "");
        div_val = 27'd0;
        runWindow("div0", rep("01", 4), rep("01", 4), rep("1", 8), "", "");
        checkOutput("div.count", 32'(tick_count), 32'd12);

        // Single step: a short glitch is rejected, a held press steps exactly once.
        $display("[TB] single step");
        mode = 2'b10;
        runWindow("stepIdle", "00", "01", "00", "", "");
        checkOutput("stepIdle.count", 32'(tick_count), 32'd12);
        btn_raw = 2'b01;
        runWindow("glitch", "00", "", "00", "00", "00");
        btn_raw = 2'b00;
        runWindow("glitchLow", rep("0", 4), "", rep("0", 4), rep("0", 4), rep("0", 4));
        checkOutput("glitch.level", 32'(btn_level), 32'd0);
        btn_raw = 2'b01;
        runWindow("press", "0000000001", rep("01", 5), rep("0", 10), "0000001000", rep("0", 10));
        checkOutput("press.level", 32'(btn_level), 32'd1);
        checkOutput("press.count", 32'(tick_count), 32'd13);
        btn_raw = 2'b00;
        runWindow("release", rep("0", 10), "", rep("0", 10), rep("0", 10), rep("0", 10));
        checkOutput("release.level", 32'(btn_level), 32'd0);

        // Break mode: halt on the third tick, resume by the second button.
        $display("[TB] break mode");
        mode = 2'b11;
        runWindow("brkRun", "000101", "", "011111", rep("0", 6), rep("0", 6));
        halt_in = 1'b1;
        runWindow("brkHalt", {"01", rep("0", 50)}, "", {"1", rep("0", 51)}, rep("0", 52), rep("0", 52));
        checkOutput("brkHalt.count", 32'(tick_count), 32'd16);
        btn_raw = 2'b10;
        runWindow("resume", {rep("0", 9), "1", rep("0", 8)}, "", {rep("0", 7), "11", rep("0", 9)},
                  rep("0", 18), {rep("0", 6), "1", rep("0", 11)});
        checkOutput("resume.count", 32'(tick_count), 32'd17);

        // Stop and restart while running.
        $display("[TB] mode stop/restart");
        btn_raw = 2'b00;
        halt_in = 1'b0;
        mode    = 2'b01;
        runWindow("restart", "0101", "", "1111", "", "0000");
        mode = 2'b00;
        runWindow("stop", rep("0", 20), "", rep("0", 20), rep("0", 20), rep("0", 20));
        mode = 2'b01;
        runWindow("rerun", "0101", "", "1111", "", "");
        checkOutput("rerun.count", 32'(tick_count), 32'd21);

        // Reset arrives while a step is pending; no tick may leak out afterwards.
        $display("[TB] reset during pending step");
        mode = 2'b10;
        runWindow("pendIdle", "0", "", "0", "", "");
        btn_raw = 2'b01;
        runWindow("pendPress", rep("0", 8), "", rep("0", 8), "00000010", "");
        rst = 1'b0;
        #1;
        checkAllZero("asyncRst");
        btn_raw = 2'b00;
        applyStimulus(3);
        checkOutput("inRst.count", 32'(tick_count), 32'd0);
        checkOutput("inRst.level", 32'(btn_level), 32'd0);
        rst = 1'b1;
        runWindow("postRst", rep("0", 20), {"0001", rep("01", 8)}, rep("0", 20), rep("0", 20), "");
        checkOutput("postRst.count", 32'(tick_count), 32'd0);

        // Tick counter wrap, preloaded just below the top while stopped.
        $display("[TB] tick counter wrap");
        mode = 2'b00;
        force dut.tick_count_q = 16'hFFFE;
        applyStimulus(3);
        release dut.tick_count_q;
        applyStimulus(1);
        checkOutput("wrap.preload", 32'(tick_count), 32'hFFFE);
        mode = 2'b01;
        waitTick("wrap.t1", 20);
        checkOutput("wrap.ffff", 32'(tick_count), 32'hFFFF);
        waitTick("wrap.t2", 20);
        checkOutput("wrap.zero", 32'(tick_count), 32'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/step_clk_ctrl.md
Name: step_clk_ctrl

Overview:
Parametrised execution-clock controller for the processor datapath and instruction ROM. It replaces the fixed slow-clock divider with a programmable divider and a one-cycle tick enable. The tick is gated by run, single-step and break modes. It also provides synchronised, debounced button edges for the step and resume buttons. The block runs entirely on the board clock and sits between the board inputs and the datapath/ROM.

Parameters:
CNT_W, 27, width of divider counter and div_val
DIV_DEFAULT, 20000, divider reload value used out of reset (half-period = DIV_DEFAULT+1 clk cycles)
NUM_BTN, 2, number of debounced buttons; bit 0 = step, bit 1 = resume
DEB_CYC, 1000000, consecutive stable cycles required to accept a button level change
DEB_W, 20, width of debounce counters (must hold DEB_CYC)

Ports:
clk  in  1  board clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
div_val  in  CNT_W  requested half-period minus one, in clk cycles
mode  in  2  00 STOP, 01 RUN, 10 STEP, 11 BREAK
btn_raw  in  NUM_BTN  raw asynchronous button inputs
halt_in  in  1  halt request from datapath
slow_clk  out  1  50% square wave with period 2*(div_act+1) cycles
tick_en  out  1  one-cycle execution enable
btn_pulse  out  NUM_BTN  one-cycle pulse on each debounced rising edge
btn_level  out  NUM_BTN  debounced button level
running  out  1  high in RUN state
tick_count  out  16  number of tick_en pulses issued

Behaviour:
- Reset (rst=0, async): all outputs 0, divider cnt=0, div_act=DIV_DEFAULT, debounce counters 0, synchronisers 0, FSM=IDLE.
- Button path, per bit:
  - 2-FF synchroniser feeds the debouncer.
  - Debounce counter clears whenever the synced value equals btn_level.
  - Otherwise the counter increments; when it reaches DEB_CYC-1, btn_level takes the synced value and the counter clears.
  - btn_pulse asserts for exactly one cycle in the cycle after btn_level rises 0->1.
  - Latency from a clean raw edge to btn_pulse = 2 (sync) + DEB_CYC + 1 cycles.
- Divider:
  - cnt counts 0..div_act; wrap = (cnt==div_act); at wrap cnt returns to 0 and slow_clk toggles.
  - div_act reloads from div_val only at wrap, so mid-period changes never produce a short phase.
  - div_val=0 toggles slow_clk every cycle.
  - rise = wrap while slow_clk==0, i.e. the cycle in which slow_clk goes 0->1.
- FSM states are IDLE, RUN, PEND and BRK. mode is sampled every cycle. A mode change forces IDLE in the next cycle, except that a change to RUN enters RUN directly from any state.
  - IDLE: mode 01 or 11 -> RUN; mode 10 with btn_pulse[0] -> PEND; otherwise stay.
  - RUN: tick_en=rise. In mode 11, halt_in=1 in a rise cycle still issues that tick, and the FSM goes to BRK next cycle. In mode 01, halt_in is ignored.
  - PEND: tick_en=rise; after the tick is issued -> IDLE. Further btn_pulse[0] while in PEND is dropped (no queuing).
  - BRK: no ticks; btn_pulse[1] -> RUN; halt_in still high at resume is ignored until the next rise.
  - mode 00: no ticks in any state.
- tick_en is registered with slow_clk, so both change in the same cycle. tick_en is never high for two consecutive cycles.
- running=1 only in RUN.
- tick_count increments on each tick_en and wraps 0xFFFF->0x0000.
- Simultaneous events:
  - Mode change and rise in the same cycle: the tick is decided by the pre-change state.
  - btn_pulse[0] and rise in the same IDLE cycle: no tick; the step fires on the next rise.
- Reset mid-operation aborts any pending step; a removed reset leaves the FSM in IDLE.

Test Plan:
- Bench parameters: DEB_CYC=4, DIV_DEFAULT=3, mode=01, no buttons; release reset -> slow_clk period 8 cycles, tick_en pulse once per 8 cycles coincident with slow_clk rising, running=1, tick_count=5 after 5 rises.
- div_val changed 3->1 mid-phase -> current half-period still 4 cycles, following half-periods 2 cycles; div_val=0 -> slow_clk toggles every cycle, tick every 2 cycles.
- mode=10, btn_raw[0] with 2-cycle glitch then held 10 cycles -> no pulse for the glitch; exactly one btn_pulse[0] 7 cycles after the stable edge; exactly one tick_en at the next rise; tick_count +1; FSM back to IDLE.
- mode=11, halt_in=1 asserted before the 3rd rise -> 3 ticks total then none for 50 cycles, running=0. btn_raw[1] press -> btn_pulse[1], running=1, ticks resume at the next rise.
- mode 01 -> 00 -> 01 during run, and async rst=0 while PEND -> no ticks while 00; after reset all outputs 0 and no stale step tick.
- Force 65535 ticks via mode=01, div_val=0, then one more -> tick_count wraps to 0x0000.
